// File: rtl/xor_checksum.sv
// xor_checksum: pairwise XOR (mode 0) or per-frame XOR checksum (mode 1) with valid/ready handshakes.
//   clk         : rising-edge clock
//   rst_n       : asynchronous active-low reset
//   din_valid   : input beat valid
//   din_ready   : registered, high in IDLE/ACC, low in OUT
//   din_a/din_b : operands, WIDTH bits
//   din_last    : final beat of a frame (mode 1 only)
//   mode        : 0 = pairwise XOR, 1 = frame checksum (sampled on the first beat)
//   dout_valid  : result valid (state OUT)
//   dout_ready  : downstream accepts the result
//   dout        : result word
//   dout_parity : XOR-reduction of dout
//   dout_len    : beats in the result frame, saturating
module xor_checksum #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             din_valid,
   output logic             din_ready,
   input  logic [WIDTH-1:0] din_a,
   input  logic [WIDTH-1:0] din_b,
   input  logic             din_last,
   input  logic             mode,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic [WIDTH-1:0] dout,
   output logic             dout_parity,
   output logic [CNT_W-1:0] dout_len
);
   typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;
   state_t state;
   logic [WIDTH-1:0] acc, acc_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic take, done;
   // ACC is only reachable in mode 1, so mode matters only for the first beat in IDLE
   always_comb begin
      acc_nx = (state == ACC) ? acc ^ din_a ^ din_b : din_a ^ din_b;
      cnt_nx = (state == ACC) ? (&cnt ? cnt : cnt + 1'b1) : CNT_W'(1);
      take   = din_valid & din_ready;
      done   = din_last | (state == IDLE && !mode);
   end
   assign dout_valid  = (state == OUT);
   assign dout_parity = ^dout;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         din_ready <= 1'b0;
         acc       <= '0;
         cnt       <= '0;
         dout      <= '0;
         dout_len  <= '0;
      end else begin
         case (state)
            IDLE, ACC: begin
               din_ready <= 1'b1;
               if (take) begin
                  acc <= acc_nx;
                  cnt <= cnt_nx;
                  if (done) begin
                     dout      <= acc_nx;
                     dout_len  <= cnt_nx;
                     state     <= OUT;
                     din_ready <= 1'b0;
                  end else begin
                     state <= ACC;
                  end
               end
            end
            OUT: begin
               if (dout_ready) begin
                  state     <= IDLE;
                  din_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_xor_checksum.sv
// tb_xor_checksum: randomized and directed self-checking bench for xor_checksum (CNT_W=8 and CNT_W=2 instances).
module tb_xor_checksum;
   logic clk = 0, rst_n = 0, din_valid = 0, din_last = 0, mode = 0, dout_ready = 0;
   logic [7:0] din_a = 0, din_b = 0;
   logic din_ready, dout_valid, dout_parity;
   logic [7:0] dout, dout_len;
   logic din_ready_s, dout_valid_s, dout_parity_s;
   logic [7:0] dout_s;
   logic [1:0] dout_len_s;
   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   xor_checksum #(.WIDTH(8), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din_ready(din_ready),
      .din_a(din_a), .din_b(din_b), .din_last(din_last), .mode(mode),
      .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout),
      .dout_parity(dout_parity), .dout_len(dout_len)
   );

   xor_checksum #(.WIDTH(8), .CNT_W(2)) dut_s (
      .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din_ready(din_ready_s),
      .din_a(din_a), .din_b(din_b), .din_last(din_last), .mode(mode),
      .dout_valid(dout_valid_s), .dout_ready(dout_ready), .dout(dout_s),
      .dout_parity(dout_parity_s), .dout_len(dout_len_s)
   );

   // Present one beat from a negedge; returns at the negedge after it transfers.
   task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic last, input logic m);
      int t = 0;
      din_a = a; din_b = b; din_last = last; mode = m; din_valid = 1;
      while (!din_ready && t < 50) begin @(negedge clk); t++; end
      checks++;
      if (!din_ready) begin
         failures++;
         $display("FAIL beat_accept: din_ready=%b required 1 within 50 cycles", din_ready);
      end else @(negedge clk);
      din_valid = 0;
      mode = 1'($urandom);
      din_last = 1'($urandom);
      din_a = 8'($urandom);
      din_b = 8'($urandom);
   endtask

   // Wait for a result, hold it under backpressure, check it, then accept it.
   task automatic get_result(input logic [7:0] ed, input int len, input int hold);
      int t = 0;
      logic ep;
      ep = 1'($countones(ed) % 2);
      while (!dout_valid && t < 50) begin @(negedge clk); t++; end
      checks++;
      if (!dout_valid) begin
         failures++;
         $display("FAIL result_timeout: dout_valid=%b required 1", dout_valid);
      end
      repeat (hold) @(negedge clk);
      checks++;
      if (dout !== ed) begin failures++; $display("FAIL dout: got %h required %h", dout, ed); end
      checks++;
      if (dout_parity !== ep) begin failures++; $display("FAIL dout_parity: got %b required %b", dout_parity, ep); end
      checks++;
      if (dout_len !== 8'(len)) begin failures++; $display("FAIL dout_len: got %0d required %0d", dout_len, len); end
      checks++;
      if (dout_len_s !== 2'(len > 3 ? 3 : len) || dout_s !== ed || dout_valid_s !== 1'b1) begin
         failures++;
         $display("FAIL sat_inst: len=%0d dout=%h valid=%b required len=%0d dout=%h valid=1",
                  dout_len_s, dout_s, dout_valid_s, (len > 3 ? 3 : len), ed);
      end
      dout_ready = 1;
      @(negedge clk);
      dout_ready = 0;
      checks++;
      if (dout_valid !== 1'b0 || din_ready !== 1'b1) begin
         failures++;
         $display("FAIL after_accept: dout_valid=%b din_ready=%b required 0 1", dout_valid, din_ready);
      end
   endtask

   task automatic test_reset;
      beat(8'h3C, 8'h00, 1'b0, 1'b0);
      #2 rst_n = 0;
      #1;
      checks++;
      if (din_ready !== 0 || dout_valid !== 0 || dout !== 0 || dout_parity !== 0 || dout_len !== 0) begin
         failures++;
         $display("FAIL reset_async: ready=%b valid=%b dout=%h par=%b len=%0d required all 0",
                  din_ready, dout_valid, dout, dout_parity, dout_len);
      end
      @(negedge clk);
      rst_n = 1;
      #1;
      checks++;
      if (din_ready !== 0) begin failures++; $display("FAIL reset_release: din_ready=%b required 0 before edge", din_ready); end
      @(negedge clk);
      checks++;
      if (din_ready !== 1 || dout_valid !== 0) begin
         failures++;
         $display("FAIL reset_first_edge: din_ready=%b dout_valid=%b required 1 0", din_ready, dout_valid);
      end
   endtask

   task automatic test_mode0;
      beat(8'hA5, 8'h0F, 1'b0, 1'b0);
      checks++;
      if (dout_valid !== 1 || dout !== 8'hAA) begin
         failures++;
         $display("FAIL mode0_latency: dout_valid=%b dout=%h required 1 aa", dout_valid, dout);
      end
      get_result(8'hAA, 1, 0);
   endtask

   task automatic test_frame;
      beat(8'h01, 8'h02, 1'b0, 1'b1);
      mode = 0;
      repeat (2) @(negedge clk);
      checks++;
      if (dout_valid !== 0 || din_ready !== 1) begin
         failures++;
         $display("FAIL acc_hold: dout_valid=%b din_ready=%b required 0 1", dout_valid, din_ready);
      end
      beat(8'h04, 8'h08, 1'b0, 1'b0);
      beat(8'h10, 8'h20, 1'b1, 1'b0);
      get_result(8'h3F, 3, 0);
   endtask

   task automatic test_backpressure;
      logic [7:0] a, b;
      a = 8'($urandom); b = 8'($urandom);
      beat(a, b, 1'b0, 1'b0);
      din_valid = 1;
      repeat (5) begin
         din_a = 8'($urandom); din_b = 8'($urandom); mode = 1'($urandom);
         @(negedge clk);
         checks++;
         if (dout !== (a ^ b) || din_ready !== 0 || dout_valid !== 1) begin
            failures++;
            $display("FAIL backpressure: dout=%h ready=%b valid=%b required %h 0 1", dout, din_ready, dout_valid, a ^ b);
         end
      end
      din_valid = 0;
      get_result(a ^ b, 1, 0);
   endtask

   task automatic test_reset_midframe;
      beat(8'h55, 8'h12, 1'b0, 1'b1);
      beat(8'h99, 8'h34, 1'b0, 1'b1);
      #2 rst_n = 0;
      #1;
      @(negedge clk);
      rst_n = 1;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (dout_valid !== 0) begin failures++; $display("FAIL reset_discard: dout_valid=%b required 0", dout_valid); end
      end
      beat(8'hFF, 8'h00, 1'b1, 1'b1);
      get_result(8'hFF, 1, 0);
   endtask

   task automatic test_saturation;
      logic [7:0] a, b, x;
      x = 0;
      for (int i = 0; i < 5; i++) begin
         a = 8'($urandom); b = 8'($urandom);
         x ^= a ^ b;
         beat(a, b, i == 4, i == 0 ? 1'b1 : 1'($urandom));
      end
      get_result(x, 5, 0);
   endtask

   task automatic test_random;
      logic [7:0] a, b, x;
      logic m;
      int n;
      for (int f = 0; f < 40; f++) begin
         m = 1'($urandom);
         n = m ? int'($urandom_range(1, 6)) : 1;
         x = 0;
         for (int i = 0; i < n; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            x ^= a ^ b;
            if (i == 0) beat(a, b, m ? (n == 1) : 1'($urandom), m);
            else beat(a, b, i == n - 1, 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         get_result(x, n, int'($urandom_range(0, 3)));
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      test_reset;
      test_mode0;
      test_frame;
      test_backpressure;
      test_reset_midframe;
      test_saturation;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
